alu_share_ctrl: RTL and testbench

- Sequencer/arbiter that time-shares one instance of the team's 4-bit ALU between two requesters.
- ALU ops: 00 concat, 01 binary add, 10 BCD add, 11 4x4 multiply.
- Accepts one operation at a time through per-requester valid/ready handshakes and registers the operands into the ALU.
- Captures the 8-bit result and returns it on a single response channel, tagged with the requester id and a BCD-operand error flag.

---
 rtl/alu_share_ctrl_pkg.sv | 19 +
 rtl/alu_share_ctrl_alu.sv | 35 +++
 rtl/alu_share_ctrl.sv | 111 +++++++++++
 tb/tb_alu_share_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared op codes and sequencer state encoding
//
// Purpose: constants used by the ALU sharing sequencer and its ALU instance.
//   OP_CAT / OP_BIN / OP_BCD / OP_MUL : 2-bit ALU select codes
//   state_t                           : sequencer states IDLE, EXEC, RESP
package alu_share_ctrl_pkg;

    localparam logic [1:0] OP_CAT = 2'b00;
    localparam logic [1:0] OP_BIN = 2'b01;
    localparam logic [1:0] OP_BCD = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// rtl/alu_share_ctrl_alu.sv - 4-bit ALU: concat, binary add, BCD add, multiply
//
// Purpose: purely combinational 4-bit ALU with an 8-bit result.
// Ports:
//   a, b : 4-bit operands
//   op   : ALU select (OP_CAT, OP_BIN, OP_BCD, OP_MUL)
//   y    : 8-bit result, never truncated
module alu_share_ctrl_alu
    import alu_share_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [7:0] y
);

    logic [7:0] sum;

    assign sum = {4'd0, a} + {4'd0, b};

    always_comb begin
        y = 8'h00;
        case (op)
            OP_CAT: y = {a, b};
            OP_BIN: y = sum;
            // Decimal adjust: a binary sum above 9 gets +6 so the tens digit
            // lands in the upper nibble. Non-decimal operands pass through the
            // same adjustment; the sequencer flags them separately.
            OP_BCD: y = (sum > 8'd9) ? sum + 8'd6 : sum;
            OP_MUL: y = {4'd0, a} * {4'd0, b};
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - time-shares one 4-bit ALU between two requesters
//
// Purpose: arbitrates two valid/ready request channels onto a single ALU,
// registers the operands, and returns the 8-bit result on one response
// channel tagged with the requester id and a BCD operand error flag.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   req0_valid/ready/a/b/op           : requester 0 operation channel
//   req1_valid/ready/a/b/op           : requester 1 operation channel
//   rsp_valid/ready/y/id/err          : result channel
//   busy                              : high whenever not IDLE
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    state_t     state;
    logic [3:0] opa;
    logic [3:0] opb;
    logic [1:0] opc;
    logic       op_id;
    logic       prio;       // requester favoured on the next contended grant
    logic       grant_any;
    logic       grant_id;
    logic [7:0] alu_y;

    always_comb begin
        grant_any = (state == IDLE) && (req0_valid || req1_valid);
        grant_id  = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = (RR_EN != 0) ? prio : 1'b0;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;
    assign busy       = (state != IDLE);

    alu_share_ctrl_alu u_alu (
        .a  (opa),
        .b  (opb),
        .op (opc),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa       <= 4'd0;
            opb       <= 4'd0;
            opc       <= 2'd0;
            op_id     <= 1'b0;
            prio      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_y     <= 8'h00;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        opa   <= grant_id ? req1_a  : req0_a;
                        opb   <= grant_id ? req1_b  : req0_b;
                        opc   <= grant_id ? req1_op : req0_op;
                        op_id <= grant_id;
                        // Pointer only moves on a grant, idle cycles keep it.
                        prio  <= ~grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_id    <= op_id;
                    rsp_err   <= (opc == OP_BCD) && ((opa > 4'd9) || (opb > 4'd9));
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Back to IDLE only; the next grant waits one more cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
    logic [7:0] rsp_y;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_busy;
    logic [7:0] fp_rsp_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    alu_share_ctrl #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(fp_rsp_y), .rsp_id(fp_rsp_id), .rsp_err(fp_rsp_err), .busy(fp_busy)
    );

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] y;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single requester op with rsp_ready held high: fixed 3-cycle sequence.
    task automatic issue(input vec_t v);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end
        #1;
        check("ready_granted", v.id ? req1_ready : req0_ready, 1);
        check("ready_other",   v.id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("exec_busy", busy, 1);
        check("exec_no_rsp", rsp_valid, 0);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_y", rsp_y, v.y);
        check("rsp_id", rsp_id, v.id);
        check("rsp_err", rsp_err, v.err);
        @(negedge clk);
        check("busy_after_hs", busy, 0);
        check("valid_after_hs", rsp_valid, 0);
    endtask

    initial begin
        logic       grants[$];
        int         rsp_idx;
        int         n0;
        int         fp0;
        int         fp1;
        logic [7:0] hold_y;
        logic       hold_id;
        logic       hold_err;

        vecs[0] = '{1'b0, 4'h7, 4'h5, 2'b01, 8'h0C, 1'b0};
        vecs[1] = '{1'b1, 4'h9, 4'h8, 2'b10, 8'h17, 1'b0};
        vecs[2] = '{1'b0, 4'hC, 4'h1, 2'b10, 8'h13, 1'b1};
        vecs[3] = '{1'b1, 4'hF, 4'hF, 2'b11, 8'hE1, 1'b0};
        vecs[4] = '{1'b0, 4'hA, 4'h3, 2'b00, 8'hA3, 1'b0};
        vecs[5] = '{1'b1, 4'h3, 4'h4, 2'b10, 8'h07, 1'b0};
        vecs[6] = '{1'b0, 4'h9, 4'hA, 2'b10, 8'h19, 1'b1};
        vecs[7] = '{1'b1, 4'hF, 4'hF, 2'b01, 8'h1E, 1'b0};
        vecs[8] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h00, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 4'h0; req0_b = 4'h0; req0_op = 2'b00;
        req1_a = 4'h0; req1_b = 4'h0; req1_op = 2'b00;

        @(negedge clk);
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_y", rsp_y, 8'h00);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_busy", busy, 0);
        check("reset_ready0", req0_ready, 0);
        check("reset_ready1", req1_ready, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) issue(vecs[i]);

        // Both requesters valid continuously.
        do_reset();
        req0_a = 4'hF; req0_b = 4'hF; req0_op = 2'b11;
        req1_a = 4'hA; req1_b = 4'h3; req1_op = 2'b00;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp_idx = 0; fp0 = 0; fp1 = 0;
        for (int c = 0; c < 40 && rsp_idx < 8; c++) begin
            #1;
            if (req0_ready) grants.push_back(1'b0);
            if (req1_ready) grants.push_back(1'b1);
            if (fp_req0_ready) fp0++;
            if (fp_req1_ready) fp1++;
            if (fp_rsp_valid) check("fp_rsp_y", fp_rsp_y, 8'hE1);
            if (rsp_valid && rsp_idx < grants.size()) begin
                check("rr_rsp_id", rsp_id, grants[rsp_idx]);
                check("rr_rsp_y", rsp_y, grants[rsp_idx] ? 8'hA3 : 8'hE1);
                rsp_idx++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_rsp_count", rsp_idx, 8);
        check("rr_grant_count", grants.size() >= 8, 1);
        n0 = 0;
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
            check("rr_grant_order", grants[k], k % 2);
            if (!grants[k]) n0++;
        end
        check("rr_half_req0", n0, 4);
        check("fp_req1_never", fp1, 0);
        check("fp_req0_grants", fp0 >= 8, 1);

        // Backpressure then reset in RESP.
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'h1; req0_op = 2'b10;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1);
        hold_y = rsp_y; hold_id = rsp_id; hold_err = rsp_err;
        check("bp_rsp_y", hold_y, 8'h13);
        check("bp_rsp_err", hold_err, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid_hold", rsp_valid, 1);
            check("bp_y_hold", rsp_y, hold_y);
            check("bp_id_hold", rsp_id, hold_id);
            check("bp_err_hold", rsp_err, hold_err);
            check("bp_no_ready", {req0_ready, req1_ready}, 2'b00);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_y", rsp_y, 8'h00);
        check("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ptr_req0", req0_ready, 1);
        check("rst_ptr_req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
